// File: rtl/arbitro_framebuffer.sv
// ============================================================================
//  Module      : arbitro_framebuffer
//  Description : Single-port frame buffer arbiter shared by video fetch,
//                full-screen clear engine and game-logic pixel writer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_framebuffer #(
    parameter int LARGURA = 640,
    parameter int ALTURA  = 480,
    parameter int AW      = 19,
    parameter int DW      = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_valid,
    output logic [DW-1:0] vid_data,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_color,
    output logic          clr_busy,
    output logic [AW-1:0] ram_endereco,
    output logic [DW-1:0] ram_data_in,
    output logic          ram_we,
    input  logic [DW-1:0] ram_data_out
);

    localparam int            N_PIXELS   = LARGURA * ALTURA;
    localparam logic [AW-1:0] c_ULTIMO   = AW'(N_PIXELS - 1);
    localparam logic [AW:0]   c_N_PIXELS = (AW + 1)'(N_PIXELS);

    typedef enum logic [0:0] {
        OCIOSO   = 1'b0,
        LIMPANDO = 1'b1
    } estado_t;

    estado_t       r_estado;
    estado_t       w_estado_prox;
    logic [AW-1:0] r_contador;
    logic [AW-1:0] w_contador_prox;
    logic [DW-1:0] r_cor_limpa;
    logic [DW-1:0] w_cor_prox;
    logic          r_vid_valid;
    logic          w_grant_vid;
    logic          w_grant_clr;
    logic          w_grant_wr;
    logic          w_wr_valido;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado    <= OCIOSO;
            r_contador  <= '0;
            r_cor_limpa <= '0;
            r_vid_valid <= 1'b0;
        end else begin
            r_estado    <= w_estado_prox;
            r_contador  <= w_contador_prox;
            r_cor_limpa <= w_cor_prox;
            r_vid_valid <= vid_req;
        end
    end

    always_comb begin
        w_estado_prox   = r_estado;
        w_contador_prox = r_contador;
        w_cor_prox      = r_cor_limpa;
        ram_endereco    = '0;
        ram_data_in     = '0;
        ram_we          = 1'b0;
        wr_ack          = 1'b0;

        // Fixed priority: video, then clear engine, then writer (idle only)
        w_grant_vid = vid_req;
        w_grant_clr = !vid_req && (r_estado == LIMPANDO);
        w_grant_wr  = !vid_req && (r_estado == OCIOSO) && !clr_start && wr_req;
        w_wr_valido = ({1'b0, wr_addr} < c_N_PIXELS);

        if (w_grant_vid) begin
            ram_endereco = vid_addr;
        end else if (w_grant_clr) begin
            ram_endereco = r_contador;
            ram_data_in  = r_cor_limpa;
            ram_we       = 1'b1;
        end else if (w_grant_wr) begin
            ram_endereco = wr_addr;
            ram_data_in  = wr_data;
            ram_we       = w_wr_valido;
            wr_ack       = 1'b1;
        end

        case (r_estado)
            OCIOSO: begin
                if (clr_start) begin
                    w_estado_prox   = LIMPANDO;
                    w_contador_prox = '0;
                    w_cor_prox      = clr_color;
                end
            end
            LIMPANDO: begin
                if (w_grant_clr) begin
                    if (r_contador == c_ULTIMO) begin
                        w_estado_prox   = OCIOSO;
                        w_contador_prox = '0;
                    end else begin
                        w_contador_prox = r_contador + 1'b1;
                    end
                end
            end
            default: w_estado_prox = OCIOSO;
        endcase

        // Strobes must stay quiet while reset is asserted, even mid-cycle
        if (!rst_n) begin
            ram_we = 1'b0;
            wr_ack = 1'b0;
        end
    end

    assign clr_busy  = (r_estado == LIMPANDO);
    assign vid_valid = r_vid_valid;
    assign vid_data  = r_vid_valid ? ram_data_out : '0;

endmodule

`default_nettype wire

// File: tb/tb_arbitro_framebuffer.sv
// ============================================================================
//  Module      : tb_arbitro_framebuffer
//  Description : Scoreboard bench for arbitro_framebuffer on a reduced screen.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arbitro_framebuffer;

    localparam int LARGURA = 16;
    localparam int ALTURA  = 8;
    localparam int AW      = 19;
    localparam int DW      = 9;
    localparam int N       = LARGURA * ALTURA;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_valid;
    logic [DW-1:0] vid_data;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ack;
    logic          clr_start = 1'b0;
    logic [DW-1:0] clr_color = '0;
    logic          clr_busy;
    logic [AW-1:0] ram_endereco;
    logic [DW-1:0] ram_data_in;
    logic          ram_we;
    logic [DW-1:0] ram_data_out = '0;

    arbitro_framebuffer #(
        .LARGURA(LARGURA), .ALTURA(ALTURA), .AW(AW), .DW(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_valid(vid_valid), .vid_data(vid_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
        .ram_endereco(ram_endereco), .ram_data_in(ram_data_in),
        .ram_we(ram_we), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Registered-read single-port RAM sitting behind the arbiter
    logic [DW-1:0] ram [0:N-1];
    always @(posedge clk) begin
        if (ram_we) ram[ram_endereco] <= ram_data_in;
        ram_data_out <= ram[ram_endereco];
    end

    // Reference model: screen contents and clear progress
    logic [DW-1:0] ref_mem [0:N-1];
    bit            m_busy  = 1'b0;
    int            m_pos   = 0;
    logic [DW-1:0] m_color = '0;

    logic [DW-1:0] sb_q [$];
    int            n_vec = 0;
    int            n_err = 0;
    int            busy_seen = 0;
    int            stalls_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every video request must yield its pixel exactly one cycle later
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb_q.size() > 0) begin
                logic [DW-1:0] e;
                e = sb_q.pop_front();
                chk("vid_valid", {31'b0, vid_valid}, 32'd1);
                chk("vid_data", {23'b0, vid_data}, {23'b0, e});
            end else if (vid_valid !== 1'b0 || vid_data !== '0) begin
                chk("vid_idle", {22'b0, vid_valid, vid_data}, 32'd0);
            end
        end
    end

    task automatic ciclo(input logic vr, input logic [AW-1:0] va,
                         input logic wq, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic cs, input logic [DW-1:0] cc, output logic ack_exp);
        bit g_clr, g_wr, we_e;
        @(negedge clk);
        vid_req = vr; vid_addr = va;
        wr_req = wq; wr_addr = wa; wr_data = wd;
        clr_start = cs; clr_color = cc;
        #1;
        g_clr = m_busy && !vr;
        g_wr  = !m_busy && !vr && !cs && wq;
        we_e  = g_clr || (g_wr && (wa < AW'(N)));
        ack_exp = g_wr;
        chk("wr_ack", {31'b0, wr_ack}, {31'b0, g_wr});
        chk("ram_we", {31'b0, ram_we}, {31'b0, we_e});
        chk("clr_busy", {31'b0, clr_busy}, {31'b0, m_busy});
        if (vr)
            chk("ram_addr_vid", 32'(ram_endereco), 32'(va));
        else if (g_clr)
            chk("ram_addr_clr", 32'(ram_endereco), 32'(m_pos));
        else if (we_e)
            chk("ram_wr", {4'b0, ram_endereco, ram_data_in}, {4'b0, wa, wd});
        if (clr_busy) busy_seen++;
        if (clr_busy && vr) stalls_seen++;
        if (vr) sb_q.push_back(ref_mem[va]);
        @(posedge clk);
        if (g_wr && wa < AW'(N)) ref_mem[wa] = wd;
        if (m_busy) begin
            if (g_clr) begin
                ref_mem[m_pos] = m_color;
                m_pos++;
                if (m_pos == N) m_busy = 1'b0;
            end
        end else if (cs) begin
            m_busy = 1'b1; m_pos = 0; m_color = cc;
        end
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) ciclo(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, a);
    endtask

    task automatic ler(input logic [AW-1:0] a);
        logic k;
        ciclo(1'b1, a, 1'b0, '0, '0, 1'b0, '0, k);
    endtask

    initial begin
        logic          ack;
        logic          pend;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        int            bound;

        for (int i = 0; i < N; i++) begin ram[i] = '0; ref_mem[i] = '0; end

        // Reset state, with a writer request pending to prove ack is gated
        wr_req = 1'b1; wr_addr = 19'd5; wr_data = 9'h1AB;
        #2;
        chk("rst_vid_valid", {31'b0, vid_valid}, 32'd0);
        chk("rst_clr_busy", {31'b0, clr_busy}, 32'd0);
        chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
        chk("rst_wr_ack", {31'b0, wr_ack}, 32'd0);
        wr_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Write then read back
        ciclo(1'b0, '0, 1'b1, 19'd100, 9'h1C0, 1'b0, '0, ack);
        ler(19'd100);
        idle(1);

        // Video and writer collide: video wins, writer acked next cycle
        ciclo(1'b1, 19'd100, 1'b1, 19'd7, 9'h055, 1'b0, '0, ack);
        ciclo(1'b0, '0, 1'b1, 19'd7, 9'h055, 1'b0, '0, ack);
        ler(19'd7);

        // Clear with no video: busy for exactly N cycles
        busy_seen = 0;
        ciclo(1'b0, '0, 1'b0, '0, '0, 1'b1, 9'h007, ack);
        idle(N + 4);
        chk("clr_duration", busy_seen, N);
        ler(19'd0); ler(19'(N / 2)); ler(19'(N - 1)); ler(19'd100);
        idle(1);

        // Clear with video every other cycle and a writer held high
        busy_seen = 0; stalls_seen = 0;
        ciclo(1'b0, '0, 1'b0, '0, '0, 1'b1, 9'h138, ack);
        pend = 1'b1; pa = 19'd33; pd = 9'h0F1;
        bound = 0;
        while ((m_busy || pend) && bound < 3 * N) begin
            ciclo(bound[0], 19'($urandom_range(N - 1)), pend, pa, pd, 1'b0, '0, ack);
            if (ack) begin
                pend = 1'b0;
                chk("ack_after_clear", busy_seen, N + stalls_seen);
            end
            bound++;
        end
        chk("clr_stall_timeout", {31'b0, pend}, 32'd0);
        chk("clr_stall_duration", busy_seen, N + stalls_seen);
        idle(1);
        ler(19'd33); ler(19'd34);

        // Out-of-range write is acked but dropped
        ciclo(1'b0, '0, 1'b1, 19'(N), 9'h1FF, 1'b0, '0, ack);
        idle(1);

        // Randomized traffic with occasional clears
        pend = 1'b0; pa = '0; pd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!pend && ($urandom % 3 == 0)) begin
                pend = 1'b1;
                pa = 19'($urandom_range(N + 3));
                pd = 9'($urandom);
            end
            ciclo(($urandom % 2) == 1, 19'($urandom_range(N - 1)), pend, pa, pd,
                  ($urandom % 60) == 0, 9'($urandom), ack);
            if (ack) pend = 1'b0;
        end
        idle(N + 4);
        for (int i = 0; i < 16; i++) ler(19'($urandom_range(N - 1)));
        idle(1);

        // Reset in the middle of a clear
        ciclo(1'b0, '0, 1'b0, '0, '0, 1'b1, 9'h0AA, ack);
        idle(40);
        @(negedge clk);
        rst_n = 1'b0;
        wr_req = 1'b1; wr_addr = 19'd3; wr_data = 9'h011;
        #1;
        chk("midrst_clr_busy", {31'b0, clr_busy}, 32'd0);
        chk("midrst_ram_we", {31'b0, ram_we}, 32'd0);
        chk("midrst_wr_ack", {31'b0, wr_ack}, 32'd0);
        m_busy = 1'b0; m_pos = 0;
        wr_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ler(19'd0); ler(19'(N - 1));
        busy_seen = 0;
        ciclo(1'b0, '0, 1'b0, '0, '0, 1'b1, 9'h1FF, ack);
        idle(N + 4);
        chk("post_rst_clr_duration", busy_seen, N);
        ler(19'd0); ler(19'(N - 1)); ler(19'd64);
        idle(3);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
